seq_twos_complement: RTL and testbench
======================================

Name: seq_twos_complement

Overview:
Multi-cycle, parametrised two's-complement arithmetic unit. It performs negate, add, subtract or absolute value on WIDTH-bit signed operands. Operands are processed DIGIT bits per clock through one shared ripple digit-adder, with a carry register between digits. It sits between the switch/operand input logic and the display/result logic, using a valid/ready handshake on both sides.

Parameters:
WIDTH, 8, operand and result width in bits; must be at least 2.
DIGIT, 1, bits processed per cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails with an error.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operands and mode are presented.
in_ready  output  1  unit can accept an operation; high only in IDLE and forced 0 while reset is high.
mode  input  2  00 NEG (-A), 01 ADD (A+B), 10 SUB (A-B), 11 ABS (|A|).
A  input  WIDTH  first operand, signed.
B  input  WIDTH  second operand, signed; ignored for NEG and ABS.
out_valid  output  1  Y and overflow are valid.
out_ready  input  1  consumer accepts the result.
Y  output  WIDTH  result.
overflow  output  1  signed overflow of the operation.

Behaviour:
- Operand mapping, latched at acceptance into effective operands x, y and carry-in c0:
  - NEG: x=~A, y=0, c0=1.
  - ADD: x=A, y=B, c0=0.
  - SUB: x=A, y=~B, c0=1.
  - ABS: if A[WIDTH-1]=1 then as NEG; else x=A, y=0, c0=0.
- States:
  - IDLE -> BUSY on in_valid & in_ready (the acceptance edge t0). That edge loads the x/y shift registers, carry<=c0 and digit count<=0.
  - BUSY: each edge adds the low DIGIT bits of x and y plus carry. The sum digit is shifted into the result register from the MSB side, carry is updated, and x/y shift right by DIGIT.
  - After N=WIDTH/DIGIT BUSY edges -> DONE. out_valid is first high in the cycle after edge t0+N.
  - DONE: Y and overflow are held stable. On out_valid & out_ready -> IDLE. A new operation cannot be accepted in that same cycle.
- Overflow = (x_msb == y_msb) & (sum_msb != x_msb), using the latched effective MSBs. Consequences:
  - NEG of the most-negative value gives Y=MIN, overflow=1.
  - ABS of MIN gives overflow=1.
- Y and overflow are registered and change only on the DONE entry edge and on reset.
- in_valid in BUSY or DONE is ignored; the operands are not captured.
- Reset (any time, including mid-BUSY): state=IDLE, Y=0, overflow=0, out_valid=0, carry=0, count=0. The aborted operation produces no result.
- out_ready while not in DONE has no effect.

Optional Feature:
SEQ_TWOS_SATURATE_EN.
- Defined: when overflow=1, Y is replaced by x_msb ? MIN (100..0) : MAX (011..1). overflow is still reported.
- Undefined: Y is the wrapped WIDTH-bit sum.

Decomposition:
- Package seq_twos_pkg:
  - mode constants MODE_NEG, MODE_ADD, MODE_SUB, MODE_ABS.
  - state encoding ST_IDLE, ST_BUSY, ST_DONE.
- Sub-module digit_adder: DIGIT-bit ripple adder with inputs a, b, cin and outputs s, cout, built from the team's full_adder. It is instantiated once.

Test Plan:
- WIDTH=8, DIGIT=1: NEG A=0x05 -> Y=0xFB, overflow=0; out_valid rises exactly 8 edges after acceptance; with DIGIT=4, after 2 edges.
- NEG A=0x80 -> Y=0x80, overflow=1 (with SEQ_TWOS_SATURATE_EN: Y=0x7F). ABS A=0xF6 -> Y=0x0A, overflow=0.
- SUB A=0x03 B=0x05 -> Y=0xFE, overflow=0. ADD A=0x7F B=0x01 -> Y=0x80, overflow=1 (saturated: 0x7F). ADD A=0x80 B=0xFF -> Y=0x7F, overflow=1 (saturated: 0x80).
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> Y/out_valid stable, in_ready=0, and an in_valid pulse with different operands is not captured. Then out_ready=1 -> IDLE, in_ready=1, and the next operation is correct.
- Assert reset 3 edges into BUSY -> out_valid=0, Y=0, overflow=0 immediately. After release, in_ready=1 and ADD 0x10+0x20 -> Y=0x30.
- Sweep all A (and B for ADD/SUB) for WIDTH=8 with DIGIT in {1,2,4,8} against a reference model, with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/seq_twos_pkg.sv
// Shared mode and state encodings for the sequential two's-complement unit.
package seq_twos_pkg;

   localparam logic [1:0] MODE_NEG = 2'b00;
   localparam logic [1:0] MODE_ADD = 2'b01;
   localparam logic [1:0] MODE_SUB = 2'b10;
   localparam logic [1:0] MODE_ABS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder built from a chain of full adders.
module digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[DIGIT];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the building block of the digit ripple adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_twos_complement.sv
// Digit-serial NEG/ADD/SUB/ABS unit with valid/ready on both sides.
// Define SEQ_TWOS_SATURATE_EN to clamp overflowing results to MIN/MAX.
module seq_twos_complement
   import seq_twos_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("seq_twos_complement: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_e           state;
   logic [WIDTH-1:0] x_sr, y_sr, res_sr;
   logic             carry;
   logic [CW-1:0]    count;
   logic             x_msb, y_msb;

   logic [WIDTH-1:0] ld_x, ld_y;
   logic             ld_c;
   logic [DIGIT-1:0] dsum;
   logic             dcout;
   logic [WIDTH-1:0] res_next, y_final;
   logic             ov_next;

   // Effective operands: every mode reduces to x + y + c0.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      ld_x = A;
      ld_y = '0;
      ld_c = 1'b0;
      case (mode)
         MODE_NEG: begin
            ld_x = ~A;
            ld_c = 1'b1;
         end
         MODE_ADD: ld_y = B;
         MODE_SUB: begin
            ld_y = ~B;
            ld_c = 1'b1;
         end
         default: begin
            if (A[WIDTH-1]) begin
               ld_x = ~A;
               ld_c = 1'b1;
            end
         end
      endcase
   end

   digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
      .a    (x_sr[DIGIT-1:0]),
      .b    (y_sr[DIGIT-1:0]),
      .cin  (carry),
      .s    (dsum),
      .cout (dcout)
   );

   // Sum digits enter from the MSB side, so after N steps res_sr is LSB-aligned.
   assign res_next = WIDTH'({dsum, res_sr} >> DIGIT);
   assign ov_next  = (x_msb == y_msb) && (dsum[DIGIT-1] != x_msb);

`ifdef SEQ_TWOS_SATURATE_EN
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;
   assign y_final = ov_next ? (x_msb ? MIN_VAL : MAX_VAL) : res_next;
`else
   assign y_final = res_next;
`endif

   assign in_ready = (state == ST_IDLE) && !reset;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         Y         <= '0;
         overflow  <= 1'b0;
         carry     <= 1'b0;
         count     <= '0;
         x_sr      <= '0;
         y_sr      <= '0;
         res_sr    <= '0;
         x_msb     <= 1'b0;
         y_msb     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  x_sr  <= ld_x;
                  y_sr  <= ld_y;
                  x_msb <= ld_x[WIDTH-1];
                  y_msb <= ld_y[WIDTH-1];
                  carry <= ld_c;
                  count <= '0;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               x_sr   <= x_sr >> DIGIT;
               y_sr   <= y_sr >> DIGIT;
               res_sr <= res_next;
               carry  <= dcout;
               count  <= count + 1'b1;
               if (count == CW'(N - 1)) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  Y         <= y_final;
                  overflow  <= ov_next;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_twos_complement.sv
// Bench: four instances (DIGIT 1/2/4/8) checked every cycle against an integer-arithmetic model.
module tb_seq_twos_complement;
   import seq_twos_pkg::*;

   localparam int W  = 8;
   localparam int NI = 4;
`ifdef SEQ_TWOS_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic           clk   = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid  [NI];
   logic           in_ready  [NI];
   logic [1:0]     mode      [NI];
   logic [W-1:0]   a_in      [NI];
   logic [W-1:0]   b_in      [NI];
   logic           out_valid [NI];
   logic           out_ready [NI];
   logic [W-1:0]   y_out     [NI];
   logic           ovf       [NI];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      seq_twos_complement #(.WIDTH(W), .DIGIT(1 << g)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .mode      (mode[g]),
         .A         (a_in[g]),
         .B         (b_in[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .Y         (y_out[g]),
         .overflow  (ovf[g])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: exact integer result, then wrap or clamp to W bits.
   function automatic logic [W:0] model(input logic [1:0] m, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
      int sa, sb, r;
      logic ov;
      logic [W-1:0] y;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (m)
         MODE_NEG: r = -sa;
         MODE_ADD: r = sa + sb;
         MODE_SUB: r = sa - sb;
         default:  r = (sa < 0) ? -sa : sa;
      endcase
      ov = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
      y  = W'(r);
      if (SAT && ov) y = (r < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return {ov, y};
   endfunction

   // Scoreboard state per instance
   bit           pending [NI];
   bit           seen    [NI];
   int           t0      [NI];
   logic [W-1:0] exp_y   [NI];
   logic         exp_ov  [NI];
   logic [W-1:0] held_y  [NI];
   logic         held_ov [NI];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Compare process: every negedge, every instance.
   initial forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         automatic int    n   = W >> k;
         automatic string tag = $sformatf("d%0d", 1 << k);
         if (reset) begin
            check({tag, "_rst_valid"}, out_valid[k], 0);
            check({tag, "_rst_y"}, y_out[k], 0);
            check({tag, "_rst_ovf"}, ovf[k], 0);
            check({tag, "_rst_ready"}, in_ready[k], 0);
            pending[k] = 1'b0;
            seen[k]    = 1'b0;
            held_y[k]  = '0;
            held_ov[k] = 1'b0;
         end else begin
            check({tag, "_in_ready"}, in_ready[k], !pending[k]);
            check({tag, "_out_valid"}, out_valid[k],
                  pending[k] && (seen[k] || (cyc - t0[k] >= n)));
            if (out_valid[k] && pending[k] && !seen[k]) begin
               seen[k]    = 1'b1;
               held_y[k]  = exp_y[k];
               held_ov[k] = exp_ov[k];
            end
            check({tag, "_y"}, y_out[k], held_y[k]);
            check({tag, "_ovf"}, ovf[k], held_ov[k]);
            if (out_valid[k] && out_ready[k] && pending[k]) pending[k] = 1'b0;
            if (in_valid[k] && in_ready[k]) begin
               pending[k] = 1'b1;
               seen[k]    = 1'b0;
               t0[k]      = cyc + 1;
               {exp_ov[k], exp_y[k]} = model(mode[k], a_in[k], b_in[k]);
            end
         end
      end
   end

   // Drivers: called at posedge+1, return at posedge+1.
   task automatic start_op(input int k, input logic [1:0] m, input logic [W-1:0] a,
                           input logic [W-1:0] b);
      bit accepted = 1'b0;
      in_valid[k] = 1'b1;
      mode[k]     = m;
      a_in[k]     = a;
      b_in[k]     = b;
      for (int i = 0; i < 50 && !accepted; i++) begin
         @(negedge clk);
         if (in_ready[k]) accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid[k] = 1'b0;
      a_in[k]     = W'($urandom);
      b_in[k]     = W'($urandom);
      mode[k]     = 2'($urandom);
      if (!accepted) check($sformatf("d%0d_accept_timeout", 1 << k), accepted, 1);
   endtask

   task automatic finish_op(input int k);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (out_valid[k] && out_ready[k]) done = 1'b1;
         @(posedge clk);
         #1;
         out_ready[k] = done ? 1'b0 : 1'($urandom_range(0, 1));
      end
      out_ready[k] = 1'b0;
      if (!done) check($sformatf("d%0d_result_timeout", 1 << k), done, 1);
   endtask

   task automatic wait_valid(input int k, output bit got);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (out_valid[k]) got = 1'b1;
      end
      if (!got) check($sformatf("d%0d_valid_timeout", 1 << k), got, 1);
   endtask

   task automatic release_op(input int k);
      @(posedge clk);
      #1 out_ready[k] = 1'b1;
      @(posedge clk);
      #1 out_ready[k] = 1'b0;
   endtask

   task automatic do_op(input int k, input logic [1:0] m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ey, input logic eo,
                        input string nm);
      bit got;
      start_op(k, m, a, b);
      wait_valid(k, got);
      if (got) begin
         check({nm, "_y"}, y_out[k], ey);
         check({nm, "_ovf"}, ovf[k], eo);
      end
      release_op(k);
   endtask

   task automatic run_op(input int k, input logic [1:0] m, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk);
         #1;
      end
      start_op(k, m, a, b);
      finish_op(k);
   endtask

   task automatic sweep(input int k);
      for (int a = 0; a < 256; a++) begin
         run_op(k, MODE_NEG, W'(a), W'($urandom));
         run_op(k, MODE_ABS, W'(a), W'($urandom));
      end
      for (int i = 0; i < 120; i++) begin
         run_op(k, MODE_ADD, W'($urandom), W'($urandom));
         run_op(k, MODE_SUB, W'($urandom), W'($urandom));
      end
      run_op(k, MODE_ADD, 8'h7F, 8'h01);
      run_op(k, MODE_ADD, 8'h80, 8'hFF);
      run_op(k, MODE_SUB, 8'h80, 8'h01);
      run_op(k, MODE_SUB, 8'h00, 8'h80);
      run_op(k, MODE_SUB, 8'h7F, 8'hFF);
   endtask

   initial begin
      bit got;
      for (int k = 0; k < NI; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
         mode[k]      = MODE_NEG;
         a_in[k]      = '0;
         b_in[k]      = '0;
      end

      // Pin the model with hand-computed values.
      check("model_neg05", model(MODE_NEG, 8'h05, 8'h00), {1'b0, 8'hFB});
      check("model_sub03_05", model(MODE_SUB, 8'h03, 8'h05), {1'b0, 8'hFE});
      check("model_abs_f6", model(MODE_ABS, 8'hF6, 8'h00), {1'b0, 8'h0A});
      check("model_add7f_01", model(MODE_ADD, 8'h7F, 8'h01), {1'b1, SAT ? 8'h7F : 8'h80});

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Directed cases on DIGIT=1, plus latency on DIGIT=4.
      do_op(0, MODE_NEG, 8'h05, 8'h33, 8'hFB, 1'b0, "neg05");
      do_op(2, MODE_NEG, 8'h05, 8'h33, 8'hFB, 1'b0, "d4_neg05");
      do_op(0, MODE_NEG, 8'h80, 8'h00, SAT ? 8'h7F : 8'h80, 1'b1, "neg80");
      do_op(0, MODE_ABS, 8'hF6, 8'h00, 8'h0A, 1'b0, "abs_f6");
      do_op(0, MODE_ABS, 8'h80, 8'h00, SAT ? 8'h7F : 8'h80, 1'b1, "abs80");
      do_op(0, MODE_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, "sub03_05");
      do_op(0, MODE_ADD, 8'h7F, 8'h01, SAT ? 8'h7F : 8'h80, 1'b1, "add7f_01");
      do_op(0, MODE_ADD, 8'h80, 8'hFF, SAT ? 8'h80 : 8'h7F, 1'b1, "add80_ff");

      // Backpressure with an ignored in_valid pulse while DONE.
      start_op(0, MODE_ADD, 8'h11, 8'h22);
      wait_valid(0, got);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) begin
            in_valid[0] = 1'b1;
            mode[0]     = MODE_SUB;
            a_in[0]     = 8'h55;
            b_in[0]     = 8'h01;
         end else begin
            in_valid[0] = 1'b0;
         end
         @(negedge clk);
         check("bp_y", y_out[0], 8'h33);
         check("bp_valid", out_valid[0], 1);
         check("bp_ready", in_ready[0], 0);
      end
      in_valid[0] = 1'b0;
      release_op(0);
      @(negedge clk);
      check("bp_ready_after", in_ready[0], 1);
      @(posedge clk);
      #1;
      do_op(0, MODE_ADD, 8'h01, 8'h02, 8'h03, 1'b0, "bp_next");

      // Reset three edges into BUSY aborts the operation.
      start_op(0, MODE_ADD, 8'h40, 8'h01);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("rst_mid_valid", out_valid[0], 0);
      check("rst_mid_y", y_out[0], 0);
      check("rst_mid_ovf", ovf[0], 0);
      check("rst_mid_ready", in_ready[0], 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_release_ready", in_ready[0], 1);
      @(posedge clk);
      #1;
      do_op(0, MODE_ADD, 8'h10, 8'h20, 8'h30, 1'b0, "rst_add10_20");

      // Randomized sweep on all four digit widths in parallel.
      fork
         sweep(0);
         sweep(1);
         sweep(2);
         sweep(3);
      join

      repeat (4) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
